// File: rtl/stack_pkg.sv
// stack_pkg: shared defaults and FSM state encoding for the operand stack
package stack_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clockSignal,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clockSignal) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO with push/pop/replace-top, registered pop result and sticky flags
module operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clockSignal,
  input  logic                   reset,
  input  logic                   psh,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       i,
  output logic [WIDTH-1:0]       o,
  output logic                   popDone,
  output logic [WIDTH-1:0]       top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_t state, state_nxt;
  logic do_pop, push_ok, pop_ok, repl, we;
  logic [AW-1:0] top_idx, waddr;
  logic [WIDTH-1:0] rdata;
  // push+pop on an empty stack degrades to a plain push
  assign do_pop  = pop & ~psh;
  assign push_ok = psh & (~pop | empty) & ~full;
  assign pop_ok  = do_pop & ~empty;
  assign repl    = psh & pop & ~empty;
  assign top_idx = count[AW-1:0] - AW'(1);
  assign waddr   = repl ? top_idx : count[AW-1:0];
  assign we      = ~reset & (push_ok | repl);
  assign top     = empty ? '0 : rdata;
  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clockSignal(clockSignal),
    .we(we),
    .waddr(waddr),
    .wdata(i),
    .raddr(top_idx),
    .rdata(rdata)
  );
  always_ff @(posedge clockSignal) state <= reset ? EMPTY : state_nxt;
  always_comb begin
    state_nxt = state == EMPTY ? (push_ok ? PARTIAL : EMPTY)
              : state == FULL  ? (pop_ok ? PARTIAL : FULL)
              : (push_ok && count == CW'(DEPTH - 1)) ? FULL
              : (pop_ok && count == CW'(1)) ? EMPTY : PARTIAL;
  end
  always_comb begin
    empty = state == EMPTY;
    full  = state == FULL;
  end
  always_ff @(posedge clockSignal) begin
    if (reset) begin
      count   <= '0;
      o       <= '0;
      popDone <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      count   <= count + CW'(push_ok) - CW'(pop_ok);
      o       <= (pop_ok | repl) ? rdata : do_pop ? '0 : o;
      popDone <= do_pop | repl;
      ovf     <= ovf | (psh & ~pop & full);
      unf     <= unf | (do_pop & empty);
    end
  end
endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of stack entries; power of two, at least 2.
REQ-003 clockSignal  in  1  sole clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 psh  in  1  push request, sampled each posedge.
REQ-006 pop  in  1  pop request, sampled each posedge.
REQ-007 i  in  WIDTH  push data, sampled when psh=1.
REQ-008 o  out  WIDTH  registered pop result, valid when popDone=1, held until the next pop.
REQ-009 popDone  out  1  one-cycle pulse, asserted the cycle after an accepted or rejected pop.
REQ-010 top  out  WIDTH  current top-of-stack (combinational from storage), 0 when empty.
REQ-011 count  out  log2(DEPTH)+1  number of occupied entries.
REQ-012 empty / full  out  1 each  count==0 / count==DEPTH.
REQ-013 ovf / unf  out  1 each  sticky overflow / underflow flags.

Function
REQ-014 FSM states: EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); the state is registered and empty/full decode from it.
REQ-015 psh=1, pop=0, not FULL: mem[count] <= i; count+1; the new value is visible on top the next cycle.
REQ-016 psh=1, pop=0, FULL: no write; count unchanged; ovf <= 1.
REQ-017 pop=1, psh=0, not EMPTY: o <= mem[count-1]; count-1; popDone=1 the next cycle (latency 1).
REQ-018 pop=1, psh=0, EMPTY: o <= 0; count unchanged; unf <= 1; popDone still pulses.
REQ-019 psh=1, pop=1, not EMPTY: replace-top; o <= old top; mem[count-1] <= i; count unchanged; popDone pulses.
REQ-020 psh=1, pop=1, EMPTY: treated as a push only, with no popDone and no unf.
REQ-021 State transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push when count==DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop when count==1; replace-top never changes state.
REQ-022 ovf/unf clear only on reset; the stack keeps operating after either flag is set.
REQ-023 count never wraps; the pointer arithmetic is WIDTH-independent and saturates by the REQ-016 and REQ-018 rules.
REQ-024 A consumer may issue back-to-back operations every cycle; there is no busy state and no wait cycles.

Reset
REQ-025 reset=1 at posedge: state EMPTY, count 0, o 0, popDone 0, ovf 0, unf 0; memory contents are don't-care.
REQ-026 Reset has priority over psh/pop in the same cycle; a pop in flight when reset asserts produces no popDone.
REQ-027 The first operation is accepted on the first posedge with reset=0.

Structure
REQ-028 Package stack_pkg holds the WIDTH/DEPTH defaults and the FSM state enumeration (EMPTY, PARTIAL, FULL).
REQ-029 Storage is the sub-module stack_ram: DEPTH x WIDTH, synchronous write, asynchronous read, one write port and one read port.
REQ-030 operand_stack contains the FSM, count, flags and the o register only.

Verification
REQ-031 Reset, then push 5, 7, 9 on consecutive cycles -> count=3, top=9, state PARTIAL.
REQ-032 From REQ-031, pop three times back-to-back -> popDone every cycle with o=9, 7, 5; then empty=1, top=0.
REQ-033 Push 0..15 (DEPTH 16), then push 99 -> full=1, ovf=1, count=16, top=15.
REQ-034 Empty stack, pop -> popDone=1, o=0, unf=1, count=0; a following push 3 -> count=1, top=3, unf still 1.
REQ-035 Stack [4,6], assert psh=1 and pop=1 together with i=8 -> o=6, top=8, count=2, popDone=1.
REQ-036 Push 1, 2, then in the same cycle assert pop and reset -> next cycle count=0, popDone=0, o=0.
